// File: rtl/ddr_pkg.sv
// Shared types and helpers for the arrow lane playfield column.
// Provides the hold-timer reload function, a row-index type and the
// per-cycle score event encoding used by arrow_lane.
package ddr_pkg;

  // Width of the light_speed hold-time select.
  localparam int SPEED_W = 4;

  // Row index into a lane; row 0 is the spawn row.
  typedef int unsigned row_idx_t;

  // At most one scoring event can occur per cycle: a hit clears the top row
  // before the shift, and a fault implies the top row was already empty, so
  // neither can coincide with a miss.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_HIT,
    EV_MISS,
    EV_FAULT
  } score_event_e;

  // Timer reload value: {1, speed} scaled up so the top five bits of the
  // hold timer carry the select. Callers truncate to their own HOLD_W.
  function automatic logic [31:0] hold_reload(input logic [SPEED_W-1:0] speed,
                                              input int hold_w);
    logic [31:0] base;
    base = {27'd0, 1'b1, speed};
    return base << (hold_w - 5);
  endfunction

endpackage

// File: rtl/lane_tick_timer.sv
// Programmable hold timer that paces arrow movement along a lane.
// Ports: clk/reset; run (lane busy) enables counting; light_speed selects
// the reload; tick is a combinational strobe in the cycle the count hits 0.
module lane_tick_timer
  import ddr_pkg::*;
#(
  parameter int HOLD_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [SPEED_W-1:0] light_speed,
  output logic               tick
);

  logic [HOLD_W-1:0] reload;
  logic [HOLD_W-1:0] timer_d;
  logic [HOLD_W-1:0] timer_q;

  assign reload = HOLD_W'(hold_reload(light_speed, HOLD_W));

  // Idle lanes park the timer at reload, so the first tick after a spawn
  // always lands a full period later.
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (!run) begin
      timer_d = reload;
    end else if (timer_q == '0) begin
      tick    = 1'b1;
      timer_d = reload;
    end else begin
      timer_d = timer_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= reload;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/arrow_lane.sv
// One playfield column: arrows spawn at row 0, climb one row per tick and
// are scored at the top row against rising edges of the player button.
// Ports: spawn/light_speed/user_press in; pxls row image, registered
// hit/miss/fault/spawn_drop pulses, saturating counters and busy out.
module arrow_lane
  import ddr_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PIX_W  = 4,
  parameter int HOLD_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spawn,
  input  logic [SPEED_W-1:0]     light_speed,
  input  logic                   user_press,
  output logic [DEPTH*PIX_W-1:0] pxls,
  output logic                   hit,
  output logic                   miss,
  output logic                   fault,
  output logic                   spawn_drop,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count,
  output logic                   busy
);

  logic [DEPTH-1:0] occ_d, occ_q;
  logic             pending_d, pending_q;
  logic             press_d, press_q;
  logic             drop_d, drop_q;
  score_event_e     ev_d, ev_q;
  logic [CNT_W-1:0] hit_cnt_d, hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_d, miss_cnt_q;

  logic             tick;
  logic             press_edge;
  logic [DEPTH-1:0] occ_scored;

  assign busy = (|occ_q) | pending_q;

  lane_tick_timer #(
    .HOLD_W (HOLD_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .run         (busy),
    .light_speed (light_speed),
    .tick        (tick)
  );

  always_comb begin
    press_d    = user_press;
    press_edge = user_press & ~press_q;
    occ_scored = occ_q;
    ev_d       = EV_NONE;

    // Scoring is applied before the shift so a press on a tick cycle
    // removes the arrow before it could exit as a miss.
    if (press_edge) begin
      if (occ_q[DEPTH-1]) begin
        occ_scored[DEPTH-1] = 1'b0;
        ev_d                = EV_HIT;
      end else begin
        ev_d = EV_FAULT;
      end
    end

    occ_d     = occ_scored;
    pending_d = pending_q | spawn;
    drop_d    = spawn & pending_q;

    // On a tick the pending arrow drains into row 0, which frees the slot
    // for a same-cycle spawn without dropping it.
    if (tick) begin
      occ_d     = {occ_scored[DEPTH-2:0], pending_q};
      pending_d = spawn;
      drop_d    = 1'b0;
      if (occ_scored[DEPTH-1]) begin
        ev_d = EV_MISS;
      end
    end

    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((ev_d == EV_HIT) && !(&hit_cnt_q)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    if ((ev_d == EV_MISS) && !(&miss_cnt_q)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      pending_q  <= 1'b0;
      press_q    <= 1'b0;
      drop_q     <= 1'b0;
      ev_q       <= EV_NONE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      pending_q  <= pending_d;
      press_q    <= press_d;
      drop_q     <= drop_d;
      ev_q       <= ev_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    pxls = '0;
    for (row_idx_t r = 0; r < DEPTH; r++) begin
      pxls[r*PIX_W +: PIX_W] = {PIX_W{occ_q[r]}};
    end
  end

  assign hit        = (ev_q == EV_HIT);
  assign miss       = (ev_q == EV_MISS);
  assign fault      = (ev_q == EV_FAULT);
  assign spawn_drop = drop_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_arrow_lane.sv
module tb_arrow_lane;

  localparam int DEPTH  = 4;
  localparam int PIX_W  = 4;
  localparam int HOLD_W = 5;
  localparam int CNT_W  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   spawn;
  logic [3:0]             light_speed;
  logic                   user_press;
  logic [DEPTH*PIX_W-1:0] pxls;
  logic                   hit, miss, fault, spawn_drop, busy;
  logic [CNT_W-1:0]       hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  // Expected snapshot of every output; flags = {busy, hit, miss, fault, drop}.
  typedef struct {
    string       tag;
    logic [15:0] px;
    logic [4:0]  flags;
    logic [1:0]  hc;
    logic [1:0]  mc;
  } exp_t;

  exp_t sb[$];

  arrow_lane #(
    .DEPTH  (DEPTH),
    .PIX_W  (PIX_W),
    .HOLD_W (HOLD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spawn       (spawn),
    .light_speed (light_speed),
    .user_press  (user_press),
    .pxls        (pxls),
    .hit         (hit),
    .miss        (miss),
    .fault       (fault),
    .spawn_drop  (spawn_drop),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] px,
                          input logic [4:0] flags, input logic [1:0] hc,
                          input logic [1:0] mc);
    exp_t e;
    e.tag   = tag;
    e.px    = px;
    e.flags = flags;
    e.hc    = hc;
    e.mc    = mc;
    sb.push_back(e);
  endtask

  task automatic check1(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cmp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check1({e.tag, ".pxls"},  32'(pxls),       32'(e.px));
    check1({e.tag, ".busy"},  32'(busy),       32'(e.flags[4]));
    check1({e.tag, ".hit"},   32'(hit),        32'(e.flags[3]));
    check1({e.tag, ".miss"},  32'(miss),       32'(e.flags[2]));
    check1({e.tag, ".fault"}, 32'(fault),      32'(e.flags[1]));
    check1({e.tag, ".drop"},  32'(spawn_drop), 32'(e.flags[0]));
    check1({e.tag, ".hcnt"},  32'(hit_count),  32'(e.hc));
    check1({e.tag, ".mcnt"},  32'(miss_count), 32'(e.mc));
  endtask

  initial begin
    reset       = 1'b1;
    spawn       = 1'b0;
    light_speed = 4'd0;
    user_press  = 1'b0;

    // Reset held three cycles, then released idle.
    push_exp("reset", 16'h0000, 5'b00000, 2'd0, 2'd0);
    step(3);
    reset = 1'b0;
    cmp();

    // Single arrow climbs and exits unstruck.
    spawn = 1'b1;
    push_exp("t2_pend", 16'h0000, 5'b10000, 2'd0, 2'd0);
    step(1);
    spawn = 1'b0;
    cmp();
    push_exp("t2_pre", 16'h0000, 5'b10000, 2'd0, 2'd0);
    step(16); cmp();
    push_exp("t2_r0", 16'h000F, 5'b10000, 2'd0, 2'd0);
    step(1); cmp();
    push_exp("t2_r1", 16'h00F0, 5'b10000, 2'd0, 2'd0);
    step(17); cmp();
    push_exp("t2_r2", 16'h0F00, 5'b10000, 2'd0, 2'd0);
    step(17); cmp();
    push_exp("t2_r3", 16'hF000, 5'b10000, 2'd0, 2'd0);
    step(17); cmp();
    push_exp("t2_exit", 16'h0000, 5'b00100, 2'd0, 2'd1);
    step(17); cmp();
    push_exp("t2_missoff", 16'h0000, 5'b00000, 2'd0, 2'd1);
    step(1); cmp();

    // Arrow struck at the top row.
    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    push_exp("t3_top", 16'hF000, 5'b10000, 2'd0, 2'd1);
    step(68); cmp();
    user_press = 1'b1;
    push_exp("t3_hit", 16'h0000, 5'b01000, 2'd1, 2'd1);
    step(1); cmp();
    user_press = 1'b0;
    push_exp("t3_quiet", 16'h0000, 5'b00000, 2'd1, 2'd1);
    step(20); cmp();

    // Early press faults; a held button never scores the later arrival.
    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    push_exp("t4_r1", 16'h00F0, 5'b10000, 2'd1, 2'd1);
    step(34); cmp();
    user_press = 1'b1;
    push_exp("t4_fault", 16'h00F0, 5'b10010, 2'd1, 2'd1);
    step(1); cmp();
    push_exp("t4_hold", 16'h00F0, 5'b10000, 2'd1, 2'd1);
    step(1); cmp();
    push_exp("t4_top", 16'hF000, 5'b10000, 2'd1, 2'd1);
    step(32); cmp();
    push_exp("t4_miss", 16'h0000, 5'b00100, 2'd1, 2'd2);
    step(17); cmp();
    user_press = 1'b0;
    step(1);

    // Second spawn while one is pending is dropped.
    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    step(1);
    spawn = 1'b1;
    push_exp("t5_drop", 16'h0000, 5'b10001, 2'd1, 2'd2);
    step(1); cmp();
    spawn = 1'b0;
    push_exp("t5_dropoff", 16'h0000, 5'b10000, 2'd1, 2'd2);
    step(1); cmp();
    push_exp("t5_r0", 16'h000F, 5'b10000, 2'd1, 2'd2);
    step(14); cmp();
    push_exp("t5_r1", 16'h00F0, 5'b10000, 2'd1, 2'd2);
    step(17); cmp();
    push_exp("t5_top", 16'hF000, 5'b10000, 2'd1, 2'd2);
    step(34); cmp();
    push_exp("t5_miss", 16'h0000, 5'b00100, 2'd1, 2'd3);
    step(17); cmp();

    // Press edge on the exact tick cycle: hit wins, no miss.
    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    push_exp("t6_top", 16'hF000, 5'b10000, 2'd1, 2'd3);
    step(68); cmp();
    step(16);
    user_press = 1'b1;
    push_exp("t6_hit", 16'h0000, 5'b01000, 2'd2, 2'd3);
    step(1); cmp();
    user_press = 1'b0;
    push_exp("t6_after", 16'h0000, 5'b00000, 2'd2, 2'd3);
    step(1); cmp();

    // Miss counter already all-ones: it must hold, not wrap.
    spawn = 1'b1;
    step(1);
    spawn = 1'b0;
    push_exp("t7_sat", 16'h0000, 5'b00100, 2'd2, 2'd3);
    step(85); cmp();

    // Spawn held through three ticks fills three rows; spawn on a tick
    // cycle is not dropped. Then reset mid-game clears everything.
    spawn = 1'b1;
    push_exp("t8_three", 16'h0FFF, 5'b10000, 2'd2, 2'd3);
    step(52); cmp();
    spawn = 1'b0;
    reset = 1'b1;
    push_exp("t8_reset", 16'h0000, 5'b00000, 2'd0, 2'd0);
    step(1); cmp();
    reset = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
